// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master bridge state encoding.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WR, WAIT_B, RD, WAIT_R, RSP
  } state_e;
endpackage

// File: rtl/axi_lite_master_bridge.sv
// AXI4-Lite initiator: one single-beat transaction at a time from a valid/ready command port,
// result returned on a valid/ready response port, with an optional abort-on-timeout.
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            tmo, aw_done, w_done;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
    end
  end

  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q  || m_axi_wready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    tmo           = 1'b0;

    // Counter saturates at the last cycle so late channel transitions still see the timeout.
    if (TO_EN && (state_q inside {WR, WAIT_B, RD, WAIT_R})) begin
      if (cnt_q == TO_LAST) tmo = 1'b1;
      else                  cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d         = '0;
          addr_d        = cmd_addr;
          wdata_d       = cmd_write ? cmd_wdata : '0;
          wstrb_d       = cmd_write ? cmd_wstrb : '0;
          rsp_write_d   = cmd_write;
          rsp_timeout_d = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD;
          end
        end
      end
      WR: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = WAIT_R;
        end
      end
      WAIT_R: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A handshake that completes on the timeout cycle still wins; otherwise abort everything.
    if (tmo && state_d == state_q) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = RESP_SLVERR;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
      state_d       = RSP;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bridge against a behavioural AXI-Lite slave with tunable ready latencies, checked end to end
// against a word-memory reference and a cycle-count latency model.
module tb_axi_lite_master_bridge;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          cmd_ready, rsp_valid, rsp_write, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  axi_lite_master_bridge #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- behavioural slave ----------------
  int  aw_lat = 0, w_lat = 0, ar_lat = 0;
  bit  ar_en = 1'b1, b_hold = 1'b0;
  int  aw_wait, w_wait, ar_wait, b_cnt;
  logic aw_have, w_have, bvalid_r, rvalid_r;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data, rdata_r;
  logic [3:0]    s_strb;
  logic [1:0]    bresp_r, rresp_r;
  bit   [31:0]   smem [16384];

  logic aw_hs, w_hs, aw_n, w_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_n;
  logic [3:0]    strb_n;
  assign awready = !aw_have && (aw_wait >= aw_lat);
  assign wready  = !w_have && ((w_lat == 0) || (aw_have && w_wait >= w_lat));
  assign arready = ar_en && !rvalid_r && (ar_wait >= ar_lat);
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign aw_n  = aw_have || aw_hs;
  assign w_n   = w_have || w_hs;
  assign addr_n = aw_have ? s_addr : awaddr;
  assign data_n = w_have ? s_data : wdata;
  assign strb_n = w_have ? s_strb : wstrb;
  assign bvalid = bvalid_r;
  assign bresp  = bresp_r;
  assign rvalid = rvalid_r;
  assign rdata  = rdata_r;
  assign rresp  = rresp_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_have <= 1'b0; w_have <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      s_addr <= '0; s_data <= '0; s_strb <= '0; rdata_r <= '0; bresp_r <= '0; rresp_r <= '0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      if (aw_have && !w_have) w_wait <= w_wait + 1;
      if (aw_hs) begin aw_have <= 1'b1; s_addr <= awaddr; aw_wait <= 0; end
      if (w_hs)  begin w_have <= 1'b1; s_data <= wdata; s_strb <= wstrb; w_wait <= 0; end
      if (aw_n && w_n && !bvalid_r && !b_hold) begin
        bvalid_r <= 1'b1;
        bresp_r  <= (addr_n >= 16'hF000) ? 2'b11 : 2'b00;
        if (addr_n < 16'hF000) smem[addr_n[15:2]] <= merge(smem[addr_n[15:2]], data_n, strb_n);
        aw_have <= 1'b0; w_have <= 1'b0; w_wait <= 0;
      end
      if (bvalid_r && bready) begin bvalid_r <= 1'b0; b_cnt <= b_cnt + 1; end
      if (!arvalid) ar_wait <= 0;
      else if (!arready) ar_wait <= ar_wait + 1;
      if (arvalid && arready) begin
        rvalid_r <= 1'b1;
        rdata_r  <= (araddr >= 16'hF000) ? 32'h0 : smem[araddr[15:2]];
        rresp_r  <= (araddr >= 16'hF000) ? 2'b11 : 2'b00;
        ar_wait  <= 0;
      end
      if (rvalid_r && rready) rvalid_r <= 1'b0;
    end
  end

  // valid-high cycle counters, sampled mid-cycle
  int awv_n = 0, wv_n = 0, arv_n = 0, cyc = 0;
  always @(negedge clk) begin
    if (awvalid) awv_n++;
    if (wvalid)  wv_n++;
    if (arvalid) arv_n++;
  end
  always @(posedge clk) cyc++;

  // ---------------- checking + reference ----------------
  int n_vec = 0, n_err = 0;
  logic [31:0] ref_m [int];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // cycles from accept edge to first rsp_valid cycle, from slave ready latencies
  function automatic int exp_lat(input bit wr, input int a, input int w, input int r);
    int taw, tw;
    if (!wr) return r + 3;
    taw = 1 + a;
    tw  = (w == 0) ? 1 : taw + w + 1;
    return ((taw > tw) ? taw : tw) + 2;
  endfunction

  task automatic do_cmd(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, input int exp_cyc, input bit exp_to);
    int t, k;
    logic [31:0] erd;
    logic [1:0]  ers;
    k   = int'(a[15:2]);
    ers = exp_to ? 2'b10 : ((a >= 16'hF000) ? 2'b11 : 2'b00);
    erd = '0;
    if (!exp_to && a < 16'hF000) begin
      if (wr) ref_m[k] = merge(ref_m.exists(k) ? ref_m[k] : 32'h0, d, s);
      else    erd = ref_m.exists(k) ? ref_m[k] : 32'h0;
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 1;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    chk("latency", t, exp_cyc);
    chk("rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, wr, exp_to, ers, erd});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata, cmd_ready},
                      {1'b1, wr, exp_to, ers, erd, 1'b0});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after", {cmd_ready, busy, rsp_valid}, 3'b100);
  endtask

  logic [15:0] pool [4] = '{16'h1000, 16'h1004, 16'h1008, 16'hF004};

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2, t;
    int stamp [10];
    logic [31:0] v;
    @(negedge clk);
    chk("reset", {cmd_ready, busy, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout,
                  rsp_resp, rsp_rdata, awaddr, wdata, wstrb},
                 {1'b1, 8'h00, 2'b00, 32'h0, 16'h0, 32'h0, 4'h0});
    @(negedge clk);
    rst_n = 1'b1;

    // basic write/read at minimum latency
    do_cmd(1, 16'h1004, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    do_cmd(0, 16'h1004, 32'h0, 4'h0, 0, 3, 0);

    // W held off 3 cycles after AW, response held 5 cycles
    w_lat = 3;
    s0 = awv_n; s1 = wv_n; s2 = b_cnt;
    do_cmd(1, 16'h1008, 32'h12345678, 4'hF, 5, exp_lat(1, 0, 3, 0), 0);
    chk("awvalid_cycles", awv_n - s0, 1);
    chk("wvalid_cycles", wv_n - s1, 5);
    chk("b_count", b_cnt - s2, 1);
    w_lat = 0;

    // AR never accepted -> timeout
    ar_en = 1'b0;
    s0 = arv_n;
    do_cmd(0, 16'h1004, 32'h0, 4'h0, 1, TO + 1, 1);
    chk("arvalid_cycles", arv_n - s0, TO);
    ar_en = 1'b1;

    // reset while waiting for B
    b_hold = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h1000; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!bready && t < 20) begin @(negedge clk); t++; end
    chk("in_wait_b", bready, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready}, 8'b00000001);
    @(negedge clk);
    chk("rst_mid_next", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready}, 8'b00000001);
    b_hold = 1'b0;
    rst_n = 1'b1;
    do_cmd(1, 16'h1000, 32'h0BADCAFE, 4'hF, 0, 3, 0);
    do_cmd(0, 16'h1000, 32'h0, 4'h0, 0, 3, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit wr;
      logic [15:0] a;
      int h;
      wr = 1'($urandom_range(0, 1));
      a  = pool[$urandom_range(0, 3)];
      aw_lat = $urandom_range(0, 3);
      w_lat  = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3);
      h = $urandom_range(0, 3);
      do_cmd(wr, a, $urandom, 4'($urandom_range(1, 15)), h, exp_lat(wr, aw_lat, w_lat, ar_lat), 0);
    end
    aw_lat = 0; w_lat = 0; ar_lat = 0;

    // ten back-to-back writes
    @(negedge clk);
    s2 = b_cnt;
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h1004; cmd_wstrb = 4'hF;
    for (int i = 0; i < 10; i++) begin
      v = $urandom;
      cmd_wdata = v;
      ref_m[int'(16'h1004 >> 2)] = v;
      t = 0;
      while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
      @(posedge clk);
      @(negedge clk);
      stamp[i] = cyc;
    end
    cmd_valid = 1'b0;
    t = 0;
    while (busy && t < 20) begin @(negedge clk); t++; end
    rsp_ready = 1'b0;
    for (int i = 1; i < 10; i++) chk("b2b_gap", stamp[i] - stamp[i-1], 4);
    chk("b2b_bcount", b_cnt - s2, 10);
    do_cmd(0, 16'h1004, 32'h0, 4'h0, 0, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
